// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared pipeline definitions used by the fetch and dependency-check stages:
// opcode field constants, the NOP instruction word, the fetch FSM state
// encoding and small opcode-decode helpers.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned ADDR_W = 10;

   // Opcode field ins[31:26]
   localparam logic [5:0] OP_JMP        = 6'b011000;
   localparam logic [5:0] OP_LOAD       = 6'b010100;
   localparam logic [5:0] OP_ST         = 6'b010101;
   localparam logic [3:0] COND_J_PREFIX = 4'b0111;

   // Bubble word inserted whenever ins_valid is low
   localparam logic [WORD_W-1:0] NOP_WORD = 32'hFC00_0000;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RUN       = 3'd1,
      S_LD_BUBBLE = 3'd2,
      S_SKID_OUT  = 3'd3,
      S_REDIRECT  = 3'd4
   } fetch_state_e;

   function automatic logic is_jmp(input logic [WORD_W-1:0] word);
      return (word[31:26] == OP_JMP);
   endfunction

   function automatic logic is_load(input logic [WORD_W-1:0] word);
      return (word[31:26] == OP_LOAD);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid_reg
// One-entry holding register for an instruction word that arrives while the
// fetch stage is emitting a load bubble.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   load           - capture word_in/pc_in and mark full
//   clear          - empty the entry (wins over load)
//   word_in, pc_in - word and its address to capture
//   word, pc, full - stored contents
// -----------------------------------------------------------------------------
module fetch_skid_reg
   import instr_fetch_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [WORD_W-1:0] word_in,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [WORD_W-1:0] word,
   output logic [ADDR_W-1:0] pc,
   output logic              full
);

   logic [WORD_W-1:0] word_q, word_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              full_q, full_d;

   // Next-entry selection: clear has priority so a redirect always wins.
   always_comb begin
      word_d = word_q;
      pc_d   = pc_q;
      full_d = full_q;
      if (clear) begin
         word_d = NOP_WORD;
         pc_d   = 10'd0;
         full_d = 1'b0;
      end else if (load) begin
         word_d = word_in;
         pc_d   = pc_in;
         full_d = 1'b1;
      end else begin
         full_d = full_q;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q <= NOP_WORD;
         pc_q   <= 10'd0;
         full_q <= 1'b0;
      end else begin
         word_q <= word_d;
         pc_q   <= pc_d;
         full_q <= full_d;
      end
   end

   assign word = word_q;
   assign pc   = pc_q;
   assign full = full_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: issues word addresses to a synchronous-read instruction memory,
// forwards returned words to the dependency-check stage, inserts one bubble
// after each LOAD (holding the in-flight word in a skid register) and one
// bubble after each JMP or taken branch.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   imem_addr, imem_en    - memory request (data returns one cycle later)
//   imem_rdata            - word for the address issued last cycle
//   br_taken, br_target   - taken-branch redirect from execute
//   ins, ins_valid, ins_pc- registered instruction, valid flag and address
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_en,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic [WORD_W-1:0] ins,
   output logic              ins_valid,
   output logic [ADDR_W-1:0] ins_pc
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d;    // address of the word in flight
   logic              fv_q, fv_d;      // a word arrives this cycle
   logic [WORD_W-1:0] ins_q, ins_d;
   logic              ins_valid_q, ins_valid_d;
   logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;

   logic              issue_s;
   logic              skid_load_s;
   logic              skid_clear_s;
   logic [WORD_W-1:0] skid_word_s;
   logic [ADDR_W-1:0] skid_pc_s;
   logic              skid_full_s;

   fetch_skid_reg u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load_s),
      .clear   (skid_clear_s),
      .word_in (imem_rdata),
      .pc_in   (fpc_q),
      .word    (skid_word_s),
      .pc      (skid_pc_s),
      .full    (skid_full_s)
   );

   // Fetch FSM next-state, pc and output-stage computation.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ins_d        = NOP_WORD;
      ins_valid_d  = 1'b0;
      ins_pc_d     = 10'd0;
      issue_s      = 1'b0;
      skid_load_s  = 1'b0;
      skid_clear_s = 1'b0;

      case (state_q)
         S_IDLE: begin
            issue_s = 1'b1;
            pc_d    = pc_q + 10'd1;
            state_d = S_RUN;
         end
         S_RUN: begin
            issue_s = 1'b1;
            pc_d    = pc_q + 10'd1;
            if (fv_q) begin
               ins_d       = imem_rdata;
               ins_valid_d = 1'b1;
               ins_pc_d    = fpc_q;
               if (is_jmp(imem_rdata)) begin
                  pc_d    = imem_rdata[9:0];
                  state_d = S_REDIRECT;
               end else if (is_load(imem_rdata)) begin
                  state_d = S_LD_BUBBLE;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_LD_BUBBLE: begin
            // Memory idles for one cycle; the word issued just before the
            // LOAD bubble is parked in the skid register.
            skid_load_s = fv_q;
            state_d     = S_SKID_OUT;
         end
         S_SKID_OUT: begin
            issue_s      = 1'b1;
            pc_d         = pc_q + 10'd1;
            skid_clear_s = 1'b1;
            if (skid_full_s) begin
               ins_d       = skid_word_s;
               ins_valid_d = 1'b1;
               ins_pc_d    = skid_pc_s;
               if (is_jmp(skid_word_s)) begin
                  pc_d    = skid_word_s[9:0];
                  state_d = S_REDIRECT;
               end else if (is_load(skid_word_s)) begin
                  state_d = S_LD_BUBBLE;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_REDIRECT: begin
            // The word arriving now belongs to the abandoned path.
            issue_s = 1'b1;
            pc_d    = pc_q + 10'd1;
            state_d = S_RUN;
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = 10'd0;
         end
      endcase

      // A taken branch overrides whatever the current state decided.
      if (br_taken) begin
         pc_d         = br_target;
         skid_load_s  = 1'b0;
         skid_clear_s = 1'b1;
         ins_d        = NOP_WORD;
         ins_valid_d  = 1'b0;
         ins_pc_d     = 10'd0;
         state_d      = S_REDIRECT;
      end else begin
         skid_clear_s = skid_clear_s;
      end

      fv_d = issue_s;
      if (issue_s) begin
         fpc_d = pc_q;
      end else begin
         fpc_d = fpc_q;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pc_q        <= 10'd0;
         fpc_q       <= 10'd0;
         fv_q        <= 1'b0;
         ins_q       <= NOP_WORD;
         ins_valid_q <= 1'b0;
         ins_pc_q    <= 10'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fpc_q       <= fpc_d;
         fv_q        <= fv_d;
         ins_q       <= ins_d;
         ins_valid_q <= ins_valid_d;
         ins_pc_q    <= ins_pc_d;
      end
   end

   // IDLE issues as soon as reset releases, so the enable is gated by reset
   // to keep the memory quiet while reset is held.
   assign imem_en   = issue_s & reset;
   assign imem_addr = pc_q;
   assign ins       = ins_q;
   assign ins_valid = ins_valid_q;
   assign ins_pc    = ins_pc_q;

endmodule
